// File: rtl/pio_debounce_irq_if.sv
// ---------------------------------------------------------------------------
// pio_debounce_irq_if
// Avalon-MM slave bus bundle for the pio_debounce_irq block.
//   address   : word address (3 bits, eight registers)
//   read      : read strobe
//   write     : write strobe
//   writedata : 32-bit write data
//   readdata  : 32-bit read data, valid the cycle after read
// Modports: master (bridge/CPU side), slave (PIO side).
// ---------------------------------------------------------------------------
interface pio_debounce_irq_if;
   logic [2:0]  address;
   logic        read;
   logic        write;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (output address, output read, output write, output writedata,
                   input readdata);
   modport slave  (input address, input read, input write, input writedata,
                   output readdata);
endinterface

// File: rtl/pio_debounce_irq.sv
// ---------------------------------------------------------------------------
// pio_debounce_irq
// Configurable Avalon-MM PIO: synchronised + debounced inputs with per-bit
// edge capture and a level interrupt, plus an output register with atomic
// set/clear writes.
// Ports:
//   clk_clk        : single clock
//   reset_reset_n  : asynchronous active-low reset
//   bus            : Avalon-MM slave (address/read/write/writedata/readdata)
//   irq            : level interrupt, |(EDGECAP & IRQMASK)
//   in_export      : asynchronous pin inputs
//   out_export     : output register
// Register map: 0 IN, 1 OUT, 2 IRQMASK, 3 EDGECAP (W1C), 4 OUTSET, 5 OUTCLR,
//   6 EDGEPOL, 7 EDGEANY.
// Optional feature macro: PIO_ANYEDGE_EN -- when defined, register 7 (EDGEANY)
//   exists and selects capture of both edges per bit; otherwise address 7
//   reads 0 and ignores writes.
// ---------------------------------------------------------------------------
module pio_debounce_irq #(
   parameter int                   IN_WIDTH        = 10,
   parameter int                   OUT_WIDTH       = 10,
   parameter int                   DEBOUNCE_CYCLES = 50000,
   parameter logic [IN_WIDTH-1:0]  IN_RESET        = '0,
   parameter logic [OUT_WIDTH-1:0] OUT_RESET       = '0
) (
   input  logic                 clk_clk,
   input  logic                 reset_reset_n,
   pio_debounce_irq_if.slave    bus,
   output logic                 irq,
   input  logic [IN_WIDTH-1:0]  in_export,
   output logic [OUT_WIDTH-1:0] out_export
);

   logic [IN_WIDTH-1:0]  sync_meta;
   logic [IN_WIDTH-1:0]  sync;
   logic [IN_WIDTH-1:0]  stable;
   logic [IN_WIDTH-1:0]  stable_prev;
   logic [IN_WIDTH-1:0]  rise;
   logic [IN_WIDTH-1:0]  fall;
   logic [IN_WIDTH-1:0]  edge_hit;
   logic [OUT_WIDTH-1:0] out_reg;
   logic [IN_WIDTH-1:0]  irq_mask;
   logic [IN_WIDTH-1:0]  edge_cap;
   logic [IN_WIDTH-1:0]  edge_pol;
   logic [IN_WIDTH-1:0]  wdata_in;
   logic [OUT_WIDTH-1:0] wdata_out;
   logic [31:0]          rd_mux;
   logic                 unused_wdata;

   assign wdata_in     = bus.writedata[IN_WIDTH-1:0];
   assign wdata_out    = bus.writedata[OUT_WIDTH-1:0];
   assign unused_wdata = ^bus.writedata;

   // Two-flop synchroniser per pin. Reset to IN_RESET so that a board whose
   // idle pin level matches IN_RESET produces no spurious edge after reset.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         sync_meta <= IN_RESET;
         sync      <= IN_RESET;
      end else begin
         sync_meta <= in_export;
         sync      <= sync_meta;
      end
   end

   generate
      if (DEBOUNCE_CYCLES == 0) begin : g_bypass
         // Debounce disabled: the stable value simply follows the synchroniser.
         always_ff @(posedge clk_clk or negedge reset_reset_n) begin
            if (!reset_reset_n) stable <= IN_RESET;
            else                stable <= sync;
         end
      end else begin : g_debounce
         localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
         localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
         logic [CNT_W-1:0] cnt [IN_WIDTH];

         // Per-bit run counter: it counts consecutive cycles in which the
         // synchronised pin disagrees with the accepted value. Any agreement
         // restarts it, so only a run of DEBOUNCE_CYCLES differing samples
         // moves the accepted value.
         always_ff @(posedge clk_clk or negedge reset_reset_n) begin
            if (!reset_reset_n) begin
               stable <= IN_RESET;
               for (int i = 0; i < IN_WIDTH; i++) cnt[i] <= '0;
            end else begin
               for (int i = 0; i < IN_WIDTH; i++) begin
                  if (sync[i] == stable[i]) begin
                     cnt[i] <= '0;
                  end else if (cnt[i] == CNT_LAST) begin
                     stable[i] <= sync[i];
                     cnt[i]    <= '0;
                  end else begin
                     cnt[i] <= cnt[i] + CNT_W'(1);
                  end
               end
            end
         end
      end
   endgenerate

   // Previous accepted value, used to spot transitions of the debounced input.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) stable_prev <= IN_RESET;
      else                stable_prev <= stable;
   end

   assign rise = stable & ~stable_prev;
   assign fall = ~stable & stable_prev;

`ifdef PIO_ANYEDGE_EN
   logic [IN_WIDTH-1:0] edge_any;

   // Any-edge bits capture both directions and override the polarity bit.
   assign edge_hit = (edge_any & (rise | fall)) |
                     (~edge_any & ((edge_pol & fall) | (~edge_pol & rise)));

   // EDGEANY control register.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n)                        edge_any <= '0;
      else if (bus.write && bus.address == 3'd7) edge_any <= wdata_in;
   end
`else
   assign edge_hit = (edge_pol & fall) | (~edge_pol & rise);
`endif

   // Control/status registers. OUT, OUTSET and OUTCLR share one register and
   // are selected by address, so at most one of them acts per cycle. For
   // EDGECAP the new capture is OR-ed in after the W1C so a simultaneous
   // edge is never lost.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         out_reg  <= OUT_RESET;
         irq_mask <= '0;
         edge_cap <= '0;
         edge_pol <= '0;
      end else begin
         if (bus.write) begin
            case (bus.address)
               3'd1:    out_reg  <= wdata_out;
               3'd2:    irq_mask <= wdata_in;
               3'd4:    out_reg  <= out_reg | wdata_out;
               3'd5:    out_reg  <= out_reg & ~wdata_out;
               3'd6:    edge_pol <= wdata_in;
               default: ;
            endcase
         end
         if (bus.write && bus.address == 3'd3) edge_cap <= (edge_cap & ~wdata_in) | edge_hit;
         else                                  edge_cap <= edge_cap | edge_hit;
      end
   end

   // Read multiplexer; registers are zero-extended and holes read as 0.
   always_comb begin
      rd_mux = '0;
      case (bus.address)
         3'd0:    rd_mux = 32'(stable);
         3'd1:    rd_mux = 32'(out_reg);
         3'd2:    rd_mux = 32'(irq_mask);
         3'd3:    rd_mux = 32'(edge_cap);
         3'd6:    rd_mux = 32'(edge_pol);
`ifdef PIO_ANYEDGE_EN
         3'd7:    rd_mux = 32'(edge_any);
`endif
         default: rd_mux = '0;
      endcase
   end

   // Read data register: loaded only on a read strobe, otherwise it holds.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) bus.readdata <= '0;
      else if (bus.read)  bus.readdata <= rd_mux;
   end

   assign irq        = |(edge_cap & irq_mask);
   assign out_export = out_reg;

endmodule

// File: tb/tb_pio_debounce_irq.sv
// ---------------------------------------------------------------------------
// tb_pio_debounce_irq
// Self-checking bench for pio_debounce_irq (IN_WIDTH=4, OUT_WIDTH=10,
// DEBOUNCE_CYCLES=8, IN_RESET=4'hF, OUT_RESET=10'h0A5). A reference model
// tracks pin history and register contents; directed scenarios are followed
// by a randomized phase and a mid-run asynchronous reset.
// ---------------------------------------------------------------------------
module tb_pio_debounce_irq;

   localparam int         IN_W   = 4;
   localparam int         OUT_W  = 10;
   localparam int         DB     = 8;
   localparam logic [3:0] IN_RST = 4'hF;
   localparam logic [9:0] OUT_RST = 10'h0A5;

   logic       clk;
   logic       reset_n;
   logic       irq;
   logic [3:0] pins;
   logic [9:0] out_export;

   int checks;
   int failures;

   pio_debounce_irq_if bus ();

   pio_debounce_irq #(
      .IN_WIDTH        (IN_W),
      .OUT_WIDTH       (OUT_W),
      .DEBOUNCE_CYCLES (DB),
      .IN_RESET        (IN_RST),
      .OUT_RESET       (OUT_RST)
   ) dut (
      .clk_clk       (clk),
      .reset_reset_n (reset_n),
      .bus           (bus),
      .irq           (irq),
      .in_export     (pins),
      .out_export    (out_export)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state
   logic [3:0]  m_stable;
   logic [3:0]  m_rise_pend;
   logic [3:0]  m_fall_pend;
   logic [9:0]  m_out;
   logic [3:0]  m_mask;
   logic [3:0]  m_cap;
   logic [3:0]  m_pol;
   logic [3:0]  m_any;
   logic [31:0] m_rd;
   logic [3:0]  hist[$];

   // Compare one observed value against the bench's expectation.
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Return the model to its post-reset contents; the two synchroniser stages
   // and the debounce window all hold IN_RESET.
   task automatic modelReset();
      m_stable    = IN_RST;
      m_rise_pend = '0;
      m_fall_pend = '0;
      m_out       = OUT_RST;
      m_mask      = '0;
      m_cap       = '0;
      m_pol       = '0;
      m_any       = '0;
      m_rd        = '0;
      hist.delete();
      for (int k = 0; k < DB + 2; k++) hist.push_back(IN_RST);
   endtask

   function automatic logic [31:0] modelRead(input logic [2:0] a);
      case (a)
         3'd0:    return 32'(m_stable);
         3'd1:    return 32'(m_out);
         3'd2:    return 32'(m_mask);
         3'd3:    return 32'(m_cap);
         3'd6:    return 32'(m_pol);
         3'd7:    return 32'(m_any);
         default: return 32'd0;
      endcase
   endfunction

   // One clock: advance the model with the inputs that were present at the
   // edge, then compare outputs shortly after the edge.
   task automatic tick();
      logic [31:0] rd_val;
      logic [3:0]  new_stable;
      logic [3:0]  qual;
      logic [3:0]  w1c;
      bit          all_diff;
      int          n;
      @(posedge clk);
      #1;
      rd_val = modelRead(bus.address);
      hist.push_back(pins);
      while (hist.size() > DB + 2) void'(hist.pop_front());
      n = hist.size();
      // A bit is accepted once the last DB synchronised samples (the pin as it
      // was two to DB+1 edges ago) all disagree with the current value.
      new_stable = m_stable;
      for (int i = 0; i < IN_W; i++) begin
         all_diff = 1'b1;
         for (int k = 0; k < DB; k++)
            if (hist[n-3-k][i] == m_stable[i]) all_diff = 1'b0;
         if (all_diff) new_stable[i] = ~m_stable[i];
      end
      // Edges accepted on the previous clock are captured on this one.
      qual = (m_any & (m_rise_pend | m_fall_pend)) |
             (~m_any & ((m_pol & m_fall_pend) | (~m_pol & m_rise_pend)));
      w1c = (bus.write && bus.address == 3'd3) ? bus.writedata[3:0] : 4'h0;
      m_cap = (m_cap & ~w1c) | qual;
      if (bus.write) begin
         case (bus.address)
            3'd1: m_out  = bus.writedata[9:0];
            3'd2: m_mask = bus.writedata[3:0];
            3'd4: m_out  = m_out | bus.writedata[9:0];
            3'd5: m_out  = m_out & ~bus.writedata[9:0];
            3'd6: m_pol  = bus.writedata[3:0];
`ifdef PIO_ANYEDGE_EN
            3'd7: m_any  = bus.writedata[3:0];
`endif
            default: ;
         endcase
      end
      m_rise_pend = new_stable & ~m_stable;
      m_fall_pend = ~new_stable & m_stable;
      m_stable    = new_stable;
      if (bus.read) m_rd = rd_val;
      checkOutput("out_export", 32'(out_export), 32'(m_out));
      checkOutput("irq", 32'(irq), 32'(|(m_cap & m_mask)));
      checkOutput("readdata", bus.readdata, m_rd);
   endtask

   // Drive one cycle of bus and pin inputs, then clock it.
   task automatic applyStimulus(input logic [2:0] a, input logic rd, input logic wr,
                                input logic [31:0] wd, input logic [3:0] p);
      bus.address   = a;
      bus.read      = rd;
      bus.write     = wr;
      bus.writedata = wd;
      pins          = p;
      tick();
   endtask

   task automatic idle(input int cycles, input logic [3:0] p);
      for (int c = 0; c < cycles; c++) applyStimulus(3'd0, 1'b0, 1'b0, 32'd0, p);
   endtask

   task automatic regWrite(input logic [2:0] a, input logic [31:0] wd, input logic [3:0] p);
      applyStimulus(a, 1'b0, 1'b1, wd, p);
   endtask

   task automatic regRead(input logic [2:0] a, input logic [3:0] p);
      applyStimulus(a, 1'b1, 1'b0, 32'd0, p);
   endtask

   initial begin
      checks        = 0;
      failures      = 0;
      bus.address   = '0;
      bus.read      = 1'b0;
      bus.write     = 1'b0;
      bus.writedata = '0;
      pins          = 4'hF;
      reset_n       = 1'b1;
      modelReset();
      #1 reset_n = 1'b0;
      #2;
      checkOutput("rst_out_export", 32'(out_export), 32'h0A5);
      checkOutput("rst_irq", 32'(irq), 32'd0);
      checkOutput("rst_readdata", bus.readdata, 32'd0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;

      // Reset contents through the bus
      regRead(3'd0, 4'hF);
      checkOutput("rst_in_reg", bus.readdata, 32'hF);
      regRead(3'd3, 4'hF);
      checkOutput("rst_edgecap", bus.readdata, 32'h0);

      // Atomic output writes
      regWrite(3'd1, 32'h0F0, 4'hF);
      regWrite(3'd4, 32'h301, 4'hF);
      checkOutput("outset", 32'(out_export), 32'h3F1);
      regWrite(3'd5, 32'h0F0, 4'hF);
      checkOutput("outclr", 32'(out_export), 32'h301);
      regRead(3'd1, 4'hF);
      checkOutput("out_readback", bus.readdata, 32'h301);

      // Debounce: a 7-cycle glitch is rejected, an 8-cycle hold is accepted
      idle(7, 4'hE);
      idle(12, 4'hF);
      regRead(3'd0, 4'hF);
      checkOutput("glitch_rejected", bus.readdata, 32'hF);
      for (int j = 1; j <= 11; j++) begin
         regRead(3'd0, 4'hE);
         if (j == 10) checkOutput("db_before_accept", bus.readdata, 32'hF);
         if (j == 11) checkOutput("db_after_accept", bus.readdata, 32'hE);
      end

      // Falling-edge interrupt and W1C
      regWrite(3'd6, 32'h1, 4'hE);
      regWrite(3'd2, 32'h1, 4'hE);
      regWrite(3'd3, 32'hF, 4'hE);
      idle(12, 4'hF);
      checkOutput("pol_fall_ignores_rise", 32'(irq), 32'd0);
      idle(12, 4'hE);
      checkOutput("irq_on_fall", 32'(irq), 32'd1);
      regRead(3'd3, 4'hE);
      checkOutput("edgecap_fall", bus.readdata, 32'h1);
      regWrite(3'd3, 32'h1, 4'hE);
      checkOutput("irq_cleared", 32'(irq), 32'd0);
      regRead(3'd3, 4'hE);
      checkOutput("edgecap_cleared", bus.readdata, 32'h0);

      // Set wins over a simultaneous W1C
      regWrite(3'd6, 32'h0, 4'hE);
      idle(12, 4'hF);
      checkOutput("irq_on_rise", 32'(irq), 32'd1);
      regWrite(3'd6, 32'h1, 4'hF);
      idle(10, 4'hE);
      regWrite(3'd3, 32'h1, 4'hE);
      checkOutput("set_wins_irq", 32'(irq), 32'd1);
      regRead(3'd3, 4'hE);
      checkOutput("set_wins_edgecap", bus.readdata, 32'h1);
      regWrite(3'd3, 32'hF, 4'hE);

`ifdef PIO_ANYEDGE_EN
      // Any-edge capture overrides the polarity bit
      regWrite(3'd7, 32'h1, 4'hE);
      idle(12, 4'hF);
      regRead(3'd3, 4'hF);
      checkOutput("anyedge_rise", bus.readdata, 32'h1);
      regWrite(3'd3, 32'hF, 4'hF);
      idle(12, 4'hE);
      regRead(3'd3, 4'hE);
      checkOutput("anyedge_fall", bus.readdata, 32'h1);
      regWrite(3'd3, 32'hF, 4'hE);
`else
      // Address 7 is a hole without the any-edge feature
      regWrite(3'd7, 32'hFFFF_FFFF, 4'hE);
      regRead(3'd7, 4'hE);
      checkOutput("addr7_reads_zero", bus.readdata, 32'h0);
`endif
      regRead(3'd5, 4'hE);
      checkOutput("wo_reads_zero", bus.readdata, 32'h0);

      // Randomized phase: sparse pin toggles (mix of glitches and long holds)
      // and random register traffic, all checked against the model.
      for (int c = 0; c < 1500; c++) begin
         logic [3:0]  p;
         logic [2:0]  a;
         logic [31:0] wd;
         int          op;
         p = pins;
         for (int i = 0; i < IN_W; i++)
            if ($urandom_range(0, 15) == 0) p[i] = ~p[i];
         a  = 3'($urandom_range(0, 7));
         wd = $urandom;
         op = $urandom_range(0, 3);
         if (op == 1)      applyStimulus(a, 1'b1, 1'b0, 32'd0, p);
         else if (op == 2) applyStimulus(a, 1'b0, 1'b1, wd, p);
         else              applyStimulus(3'd0, 1'b0, 1'b0, 32'd0, p);
      end

      // Asynchronous reset in mid-cycle returns everything to reset values
      regWrite(3'd1, 32'h35A, 4'hF);
      regRead(3'd1, 4'hF);
      #2 reset_n = 1'b0;
      #1;
      checkOutput("async_rst_out", 32'(out_export), 32'h0A5);
      checkOutput("async_rst_irq", 32'(irq), 32'd0);
      checkOutput("async_rst_readdata", bus.readdata, 32'd0);
      modelReset();
      bus.read  = 1'b0;
      bus.write = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      regRead(3'd2, 4'hF);
      checkOutput("post_rst_mask", bus.readdata, 32'h0);
      idle(4, 4'hF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
